// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin arbiter sharing one RAM port between two
//               requesters (m0 = core LSU, m1 = boot loader / debug DMA).
//               Each requester has a valid/ready request channel and a
//               valid/ready response channel with one outstanding response.
//               RAM read is combinational and is captured on the fire edge.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic                    m0_wr_en,
    input  logic [DATA_WIDTH/8-1:0] m0_wr_strobe,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_rsp_valid,
    input  logic                    m0_rsp_ready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic                    m1_wr_en,
    input  logic [DATA_WIDTH/8-1:0] m1_wr_strobe,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_rsp_valid,
    input  logic                    m1_rsp_ready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic                    ram_wr_en,
    output logic [DATA_WIDTH/8-1:0] ram_wr_strobe,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_data_in,
    input  logic [DATA_WIDTH-1:0]   ram_data_out
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Which requester was granted most recently (0 = m0, 1 = m1).
    logic                  last_grant_q, last_grant_d;
    logic                  m0_rsp_valid_q, m0_rsp_valid_d;
    logic                  m1_rsp_valid_q, m1_rsp_valid_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;

    logic                  w_elig0, w_elig1;
    logic                  w_gnt0, w_gnt1;
    logic                  w_fire0, w_fire1;

    // Eligibility and round-robin winner; a requester whose response is not
    // drained this cycle has nowhere to put a new response, so it waits.
    always_comb begin
        w_elig0 = m0_req_valid && (!m0_rsp_valid_q || m0_rsp_ready);
        w_elig1 = m1_req_valid && (!m1_rsp_valid_q || m1_rsp_ready);
        w_gnt0  = w_elig0 && (!w_elig1 ||  last_grant_q);
        w_gnt1  = w_elig1 && (!w_elig0 || !last_grant_q);
        w_fire0 = m0_req_valid && w_gnt0;
        w_fire1 = m1_req_valid && w_gnt1;
    end

    assign m0_req_ready = w_gnt0;
    assign m1_req_ready = w_gnt1;
    assign m0_rsp_valid = m0_rsp_valid_q;
    assign m1_rsp_valid = m1_rsp_valid_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;

    // Steer the winner onto the RAM port; idle port is driven to zero and
    // writes are blocked while reset is asserted.
    always_comb begin
        ram_wr_en     = 1'b0;
        ram_wr_strobe = '0;
        ram_addr      = '0;
        ram_data_in   = '0;
        if (w_fire0) begin
            ram_wr_en     = m0_wr_en;
            ram_wr_strobe = m0_wr_en ? m0_wr_strobe : {STRB_WIDTH{1'b0}};
            ram_addr      = m0_addr;
            ram_data_in   = m0_wdata;
        end else if (w_fire1) begin
            ram_wr_en     = m1_wr_en;
            ram_wr_strobe = m1_wr_en ? m1_wr_strobe : {STRB_WIDTH{1'b0}};
            ram_addr      = m1_addr;
            ram_data_in   = m1_wdata;
        end
        if (rst) begin
            ram_wr_en     = 1'b0;
            ram_wr_strobe = '0;
        end
    end

    // Next-state for responses and grant history; a fire in the same cycle
    // as a drain keeps the response valid with the freshly sampled word.
    always_comb begin
        last_grant_d   = last_grant_q;
        m0_rsp_valid_d = m0_rsp_valid_q;
        m1_rsp_valid_d = m1_rsp_valid_q;
        m0_rdata_d     = m0_rdata_q;
        m1_rdata_d     = m1_rdata_q;

        if (w_fire0) begin
            m0_rsp_valid_d = 1'b1;
            m0_rdata_d     = ram_data_out;
            last_grant_d   = 1'b0;
        end else if (m0_rsp_valid_q && m0_rsp_ready) begin
            m0_rsp_valid_d = 1'b0;
        end

        if (w_fire1) begin
            m1_rsp_valid_d = 1'b1;
            m1_rdata_d     = ram_data_out;
            last_grant_d   = 1'b1;
        end else if (m1_rsp_valid_q && m1_rsp_ready) begin
            m1_rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset drops outstanding responses and makes m0 win
    // the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q   <= 1'b1;
            m0_rsp_valid_q <= 1'b0;
            m1_rsp_valid_q <= 1'b0;
            m0_rdata_q     <= '0;
            m1_rdata_q     <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            m0_rsp_valid_q <= m0_rsp_valid_d;
            m1_rsp_valid_q <= m1_rsp_valid_d;
            m0_rdata_q     <= m0_rdata_d;
            m1_rdata_q     <= m1_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed self-checking bench for ram_port_arbiter with a
//               behavioural RAM (combinational read, byte-strobed write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        m0_req_valid, m0_req_ready, m0_wr_en, m0_rsp_valid, m0_rsp_ready;
    logic [3:0]  m0_wr_strobe;
    logic [15:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req_valid, m1_req_ready, m1_wr_en, m1_rsp_valid, m1_rsp_ready;
    logic [3:0]  m1_wr_strobe;
    logic [15:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;

    logic        ram_wr_en;
    logic [3:0]  ram_wr_strobe;
    logic [15:0] ram_addr;
    logic [31:0] ram_data_in, ram_data_out;

    logic [31:0] mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;
    int cnt0    = 0;
    int cnt1    = 0;

    ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_wr_en(m0_wr_en), .m0_wr_strobe(m0_wr_strobe), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid),
        .m0_rsp_ready(m0_rsp_ready), .m0_rdata(m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_wr_en(m1_wr_en), .m1_wr_strobe(m1_wr_strobe), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid),
        .m1_rsp_ready(m1_rsp_ready), .m1_rdata(m1_rdata),
        .ram_wr_en(ram_wr_en), .ram_wr_strobe(ram_wr_strobe),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural RAM port.
    assign ram_data_out = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr_strobe[b]) mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        mem[16'h0001] = 32'h01010101;
        mem[16'h0002] = 32'h02020202;
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h0020] = 32'hAABBCCDD;
        mem[16'h0030] = 32'h30303030;

        rst = 1'b1;
        m0_req_valid = 0; m0_wr_en = 0; m0_wr_strobe = 0; m0_addr = 0; m0_wdata = 0; m0_rsp_ready = 0;
        m1_req_valid = 0; m1_wr_en = 0; m1_wr_strobe = 0; m1_addr = 0; m1_wdata = 0; m1_rsp_ready = 0;
        #12;
        chk("rst_m0_rsp_valid", {31'b0, m0_rsp_valid}, 32'd0);
        chk("rst_m1_rsp_valid", {31'b0, m1_rsp_valid}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_ram_wr_en", {31'b0, ram_wr_en}, 32'd0);
        rst = 1'b0;

        // m0 single read of 0x0010
        tick();
        m0_req_valid = 1; m0_addr = 16'h0010; m0_rsp_ready = 1;
        #1;
        chk("t1_m0_req_ready", {31'b0, m0_req_ready}, 32'd1);
        chk("t1_m1_req_ready", {31'b0, m1_req_ready}, 32'd0);
        chk("t1_ram_addr", {16'b0, ram_addr}, 32'h0010);
        chk("t1_ram_wr_en", {31'b0, ram_wr_en}, 32'd0);
        tick();
        m0_req_valid = 0;
        chk("t1_m0_rsp_valid", {31'b0, m0_rsp_valid}, 32'd1);
        chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("t1_m1_rsp_valid", {31'b0, m1_rsp_valid}, 32'd0);
        tick();
        chk("t1_m0_drained", {31'b0, m0_rsp_valid}, 32'd0);

        // m1 strobed write then read-back of 0x0020
        m1_req_valid = 1; m1_wr_en = 1; m1_wr_strobe = 4'b0101; m1_addr = 16'h0020;
        m1_wdata = 32'h11223344; m1_rsp_ready = 1;
        #1;
        chk("t2_m1_req_ready_wr", {31'b0, m1_req_ready}, 32'd1);
        chk("t2_ram_wr_en", {31'b0, ram_wr_en}, 32'd1);
        chk("t2_ram_wr_strobe", {28'b0, ram_wr_strobe}, 32'h5);
        chk("t2_ram_data_in", ram_data_in, 32'h11223344);
        tick();
        chk("t2_wr_rsp_valid", {31'b0, m1_rsp_valid}, 32'd1);
        chk("t2_wr_rsp_rdata", m1_rdata, 32'hAABBCCDD);
        m1_wr_en = 0;
        #1;
        chk("t2_m1_req_ready_rd", {31'b0, m1_req_ready}, 32'd1);
        chk("t2_rd_strobe_zero", {28'b0, ram_wr_strobe}, 32'h0);
        tick();
        m1_req_valid = 0;
        chk("t2_rd_rsp_valid", {31'b0, m1_rsp_valid}, 32'd1);
        chk("t2_rd_rsp_rdata", m1_rdata, 32'hAA22CC44);
        tick();
        chk("t2_m1_drained", {31'b0, m1_rsp_valid}, 32'd0);

        // Saturated round-robin from reset
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m0_req_valid = 1; m0_wr_en = 0; m0_addr = 16'h0001; m0_rsp_ready = 1;
        m1_req_valid = 1; m1_wr_en = 0; m1_addr = 16'h0002; m1_rsp_ready = 1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("t3_m0_gnt_%0d", k), {31'b0, m0_req_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t3_m1_gnt_%0d", k), {31'b0, m1_req_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (m0_rsp_valid) begin
                cnt0++;
                chk($sformatf("t3_m0_rdata_%0d", k), m0_rdata, 32'h01010101);
            end
            if (m1_rsp_valid) begin
                cnt1++;
                chk($sformatf("t3_m1_rdata_%0d", k), m1_rdata, 32'h02020202);
            end
        end
        chk("t3_m0_rsp_count", cnt0, 32'd3);
        chk("t3_m1_rsp_count", cnt1, 32'd3);

        // m0 response stalled; m1 takes every grant
        m0_req_valid = 0; m1_req_valid = 0;
        tick();
        m0_req_valid = 1; m0_addr = 16'h0010; m0_rsp_ready = 0;
        tick();
        chk("t4_m0_pending", {31'b0, m0_rsp_valid}, 32'd1);
        chk("t4_m0_pending_data", m0_rdata, 32'hDEADBEEF);
        m0_addr = 16'h0001;
        m1_req_valid = 1; m1_addr = 16'h0002;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_m0_blocked_%0d", k), {31'b0, m0_req_ready}, 32'd0);
            chk($sformatf("t4_m1_gnt_%0d", k), {31'b0, m1_req_ready}, 32'd1);
            tick();
            chk($sformatf("t4_m0_rdata_hold_%0d", k), m0_rdata, 32'hDEADBEEF);
            chk($sformatf("t4_m0_valid_hold_%0d", k), {31'b0, m0_rsp_valid}, 32'd1);
        end
        m0_rsp_ready = 1;
        #1;
        chk("t4_m0_gnt_after_ready", {31'b0, m0_req_ready}, 32'd1);
        chk("t4_m1_lose_after_ready", {31'b0, m1_req_ready}, 32'd0);
        tick();
        chk("t4_m0_refire_valid", {31'b0, m0_rsp_valid}, 32'd1);
        chk("t4_m0_refire_data", m0_rdata, 32'h01010101);

        // Back-to-back m0 reads; alternate a different word in between
        m1_req_valid = 0;
        m0_addr = 16'h0010;
        tick();
        chk("t5_b2b_valid0", {31'b0, m0_rsp_valid}, 32'd1);
        chk("t5_b2b_data0", m0_rdata, 32'hDEADBEEF);
        m0_addr = 16'h0002;
        tick();
        chk("t5_b2b_valid1", {31'b0, m0_rsp_valid}, 32'd1);
        chk("t5_b2b_data1", m0_rdata, 32'h02020202);
        m0_req_valid = 0; m0_rsp_ready = 0;
        tick();
        chk("t5_m0_still_pending", {31'b0, m0_rsp_valid}, 32'd1);

        // Reset with m1 write valid and m0 response pending
        m1_req_valid = 1; m1_wr_en = 1; m1_wr_strobe = 4'b1111; m1_addr = 16'h0030;
        m1_wdata = 32'hFFFFFFFF; m1_rsp_ready = 1;
        rst = 1'b1;
        #1;
        chk("t6_async_m0_rsp_valid", {31'b0, m0_rsp_valid}, 32'd0);
        chk("t6_async_m1_rsp_valid", {31'b0, m1_rsp_valid}, 32'd0);
        chk("t6_async_m0_rdata", m0_rdata, 32'h0);
        chk("t6_ram_wr_en_in_rst", {31'b0, ram_wr_en}, 32'd0);
        tick();
        chk("t6_ram_word_kept", mem[16'h0030], 32'h30303030);
        rst = 1'b0;
        m1_wr_en = 0;
        m0_req_valid = 1; m0_addr = 16'h0001; m0_rsp_ready = 1;
        #1;
        chk("t6_tie_m0_wins", {31'b0, m0_req_ready}, 32'd1);
        chk("t6_tie_m1_loses", {31'b0, m1_req_ready}, 32'd0);
        tick();
        m0_req_valid = 0; m1_req_valid = 0;
        chk("t6_m0_rsp_after_rst", m0_rdata, 32'h01010101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
